// File: rtl/thread_select_stage_if.sv
// Shared types and the decode-to-issue interface of the thread select stage.
package thread_select_pkg;
  localparam int THREADS_PER_CORE = 4;

  typedef logic [$clog2(THREADS_PER_CORE)-1:0] local_thread_idx_t;
  typedef logic [5:0] register_idx_t;
  typedef logic [3:0] subcycle_t;

  typedef struct packed {
    logic [7:0]    opcode;
    logic          has_dest;
    logic          dest_vector;
    register_idx_t dest_reg;
    logic          has_scalar1;
    register_idx_t scalar_sel1;
    logic          has_scalar2;
    register_idx_t scalar_sel2;
    logic          has_scalar3;
    register_idx_t scalar_sel3;
    logic          has_mask;
    register_idx_t mask_sel;
    logic          has_vector1;
    register_idx_t vector_sel1;
    logic          has_vector2;
    register_idx_t vector_sel2;
    logic          has_vector3;
    register_idx_t vector_sel3;
    subcycle_t     last_subcycle;
  } decoded_instruction_t;
endpackage

interface thread_select_stage_if;
  import thread_select_pkg::*;

  logic                        id_instruction_valid;
  decoded_instruction_t        id_instruction;
  local_thread_idx_t           id_thread_idx;
  logic [THREADS_PER_CORE-1:0] ts_fetch_en;
  logic                        ts_instruction_valid;
  decoded_instruction_t        ts_instruction;
  local_thread_idx_t           ts_thread_idx;
  subcycle_t                   ts_subcycle;

  // master is the decode side, slave is the thread select stage
  modport master (
    output id_instruction_valid, id_instruction, id_thread_idx,
    input  ts_fetch_en, ts_instruction_valid, ts_instruction, ts_thread_idx, ts_subcycle
  );
  modport slave (
    input  id_instruction_valid, id_instruction, id_thread_idx,
    output ts_fetch_en, ts_instruction_valid, ts_instruction, ts_thread_idx, ts_subcycle
  );
endinterface

// File: rtl/thread_select_stage.sv
// Per-thread instruction FIFOs, register scoreboards and a round-robin issue
// arbiter feeding operand fetch, with subcycle sequencing and rollback repair.
module thread_select_stage
  import thread_select_pkg::*;
#(
  parameter int FIFO_DEPTH       = 8,
  parameter int FIFO_ALMOST_FULL = FIFO_DEPTH - 3,
  parameter int ROLLBACK_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  thread_select_stage_if.slave        bus,
  input  logic [THREADS_PER_CORE-1:0] thread_en,
  input  logic [THREADS_PER_CORE-1:0] wb_suspend_thread_oh,
  input  logic [THREADS_PER_CORE-1:0] l2_wake_thread_oh,
  input  logic                        wb_rollback_en,
  input  local_thread_idx_t           wb_rollback_thread_idx,
  input  logic                        wb_writeback_en,
  input  local_thread_idx_t           wb_writeback_thread_idx,
  input  logic                        wb_writeback_vector,
  input  register_idx_t               wb_writeback_reg
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [6:0]       sb_idx_t;
  typedef logic [127:0]     scoreboard_t;
  localparam cnt_t ALMOST_FULL = cnt_t'(FIFO_ALMOST_FULL);

  decoded_instruction_t fifo_mem [THREADS_PER_CORE][FIFO_DEPTH];
  ptr_t                 rd_ptr [THREADS_PER_CORE];
  ptr_t                 wr_ptr [THREADS_PER_CORE];
  cnt_t                 count [THREADS_PER_CORE];
  scoreboard_t          scoreboard [THREADS_PER_CORE];
  scoreboard_t          scoreboard_next [THREADS_PER_CORE];
  subcycle_t            subcycle [THREADS_PER_CORE];
  logic                 hist_valid [THREADS_PER_CORE][ROLLBACK_DEPTH];
  sb_idx_t              hist_bit [THREADS_PER_CORE][ROLLBACK_DEPTH];
  logic [THREADS_PER_CORE-1:0] suspended;
  local_thread_idx_t    rr_ptr;

  decoded_instruction_t head [THREADS_PER_CORE];
  logic [THREADS_PER_CORE-1:0] ready, rolling_back, pushing, issuing, popping, fetch_en_next;
  logic                 grant_valid;
  local_thread_idx_t    grant_idx;
  local_thread_idx_t    cand;

  // Bit index layout: {vector, reg}, so vector registers occupy the upper 64 bits.
  function automatic logic has_hazard(input decoded_instruction_t i, input scoreboard_t sb);
    return (i.has_scalar1 && sb[{1'b0, i.scalar_sel1}])
        || (i.has_scalar2 && sb[{1'b0, i.scalar_sel2}])
        || (i.has_scalar3 && sb[{1'b0, i.scalar_sel3}])
        || (i.has_mask    && sb[{1'b0, i.mask_sel}])
        || (i.has_vector1 && sb[{1'b1, i.vector_sel1}])
        || (i.has_vector2 && sb[{1'b1, i.vector_sel2}])
        || (i.has_vector3 && sb[{1'b1, i.vector_sel3}])
        || (i.has_dest    && sb[{i.dest_vector, i.dest_reg}]);
  endfunction

  always_comb begin
    ready         = '0;
    rolling_back  = '0;
    pushing       = '0;
    fetch_en_next = '0;
    for (int t = 0; t < THREADS_PER_CORE; t++) begin
      head[t]          = fifo_mem[t][rd_ptr[t]];
      rolling_back[t]  = wb_rollback_en && (wb_rollback_thread_idx == local_thread_idx_t'(t));
      pushing[t]       = bus.id_instruction_valid && (bus.id_thread_idx == local_thread_idx_t'(t))
                         && !rolling_back[t];
      // A thread mid-sequence already passed its hazard check at subcycle 0.
      ready[t]         = thread_en[t] && !suspended[t] && (count[t] != '0) && !rolling_back[t]
                         && ((subcycle[t] != '0) || !has_hazard(head[t], scoreboard[t]));
      fetch_en_next[t] = thread_en[t] && (count[t] < ALMOST_FULL) && !rolling_back[t];
    end
  end

  // Leaving rr_ptr on the granted thread until its last subcycle keeps the grant locked.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr;
    cand        = rr_ptr;
    issuing     = '0;
    popping     = '0;
    for (int i = 0; i < THREADS_PER_CORE; i++) begin
      cand = rr_ptr + local_thread_idx_t'(i);
      if (!grant_valid && ready[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    for (int t = 0; t < THREADS_PER_CORE; t++) begin
      issuing[t] = grant_valid && (grant_idx == local_thread_idx_t'(t));
      popping[t] = issuing[t] && (subcycle[t] == head[t].last_subcycle);
    end
  end

  always_comb begin
    for (int t = 0; t < THREADS_PER_CORE; t++) begin
      scoreboard_next[t] = scoreboard[t];
      if (issuing[t] && (subcycle[t] == '0) && head[t].has_dest)
        scoreboard_next[t][{head[t].dest_vector, head[t].dest_reg}] = 1'b1;
      if (wb_writeback_en && (wb_writeback_thread_idx == local_thread_idx_t'(t)))
        scoreboard_next[t][{wb_writeback_vector, wb_writeback_reg}] = 1'b0;
      if (rolling_back[t])
        for (int d = 0; d < ROLLBACK_DEPTH; d++)
          if (hist_valid[t][d]) scoreboard_next[t][hist_bit[t][d]] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int t = 0; t < THREADS_PER_CORE; t++)
      if (pushing[t]) fifo_mem[t][wr_ptr[t]] <= bus.id_instruction;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < THREADS_PER_CORE; t++) begin
        rd_ptr[t]     <= '0;
        wr_ptr[t]     <= '0;
        count[t]      <= '0;
        scoreboard[t] <= '0;
        subcycle[t]   <= '0;
        for (int d = 0; d < ROLLBACK_DEPTH; d++) begin
          hist_valid[t][d] <= 1'b0;
          hist_bit[t][d]   <= '0;
        end
      end
      suspended                <= '0;
      rr_ptr                   <= '0;
      bus.ts_fetch_en          <= '0;
      bus.ts_instruction_valid <= 1'b0;
      bus.ts_instruction       <= '0;
      bus.ts_thread_idx        <= '0;
      bus.ts_subcycle          <= '0;
    end else begin
      for (int t = 0; t < THREADS_PER_CORE; t++) begin
        scoreboard[t] <= scoreboard_next[t];
        suspended[t]  <= l2_wake_thread_oh[t] ? 1'b0 : (wb_suspend_thread_oh[t] | suspended[t]);
        if (rolling_back[t]) begin
          rd_ptr[t]   <= '0;
          wr_ptr[t]   <= '0;
          count[t]    <= '0;
          subcycle[t] <= '0;
          for (int d = 0; d < ROLLBACK_DEPTH; d++) hist_valid[t][d] <= 1'b0;
        end else begin
          if (pushing[t]) wr_ptr[t] <= wr_ptr[t] + ptr_t'(1);
          if (popping[t]) rd_ptr[t] <= rd_ptr[t] + ptr_t'(1);
          count[t] <= count[t] + cnt_t'(pushing[t]) - cnt_t'(popping[t]);
          if (issuing[t]) subcycle[t] <= popping[t] ? '0 : subcycle[t] + subcycle_t'(1);
          if (issuing[t] && (subcycle[t] == '0)) begin
            for (int d = 1; d < ROLLBACK_DEPTH; d++) begin
              hist_valid[t][d] <= hist_valid[t][d-1];
              hist_bit[t][d]   <= hist_bit[t][d-1];
            end
            hist_valid[t][0] <= head[t].has_dest;
            hist_bit[t][0]   <= {head[t].dest_vector, head[t].dest_reg};
          end
        end
      end
      bus.ts_fetch_en          <= fetch_en_next;
      bus.ts_instruction_valid <= grant_valid;
      if (grant_valid) begin
        bus.ts_instruction <= head[grant_idx];
        bus.ts_thread_idx  <= grant_idx;
        bus.ts_subcycle    <= subcycle[grant_idx];
        rr_ptr             <= popping[grant_idx] ? grant_idx + local_thread_idx_t'(1) : grant_idx;
      end
    end
  end
endmodule
